// File: rtl/store_buffer_pkg.sv
// Shared constants and entry type for the store buffer sitting between EX/MEM and dataMemory.
package store_buffer_pkg;

  localparam int DEPTH        = 4;
  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 8;
  localparam int MEM_AW       = 4;
  localparam int DRAIN_THRESH = 3;
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  // dataMemory only decodes the low MEM_AW bits, so the port address is zero-extended.
  function automatic logic [ADDR_W-1:0] dm_addr_of(input logic [MEM_AW-1:0] a);
    return {{(ADDR_W-MEM_AW){1'b0}}, a};
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// EX-side, writeback and dataMemory signals of the store buffer bundled in one interface.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic              ex_valid;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic              sb_flush;
  logic              sb_empty;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_load_data;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_write_en;
  logic              dm_read;
  logic [DATA_W-1:0] dm_rdata;

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_addr, ex_wdata, sb_flush, dm_rdata,
    output sb_empty, wb_valid, wb_load_data, dm_addr, dm_wdata, dm_write_en, dm_read
  );

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_addr, ex_wdata, sb_flush, dm_rdata,
    input  sb_empty, wb_valid, wb_load_data, dm_addr, dm_wdata, dm_write_en, dm_read
  );

endinterface

// File: rtl/store_buffer_sb_match.sv
// Parallel address compare across the valid store-buffer entries; shared by merge and forward.
module sb_match
  import store_buffer_pkg::*;
(
  input  sb_entry_t [DEPTH-1:0] i_entries,
  input  logic [DEPTH-1:0]      i_valid,
  input  logic [MEM_AW-1:0]     i_addr,
  output logic [DEPTH-1:0]      o_hit_vec,
  output logic                  o_hit,
  output logic [DATA_W-1:0]     o_hit_data
);

  // Coalescing keeps addresses unique, so at most one bit of the hit vector is ever set.
  always_comb begin
    o_hit_vec  = '0;
    o_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_valid[i] && (i_entries[i].addr == i_addr)) begin
        o_hit_vec[i] = 1'b1;
        o_hit_data   = i_entries[i].data;
      end
    end
  end

  assign o_hit = |o_hit_vec;

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues and merges stores, forwards to loads, owns the single dataMemory port.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave sb
);

  sb_entry_t [DEPTH-1:0] r_entries;
  logic [DEPTH-1:0]      r_valid;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  r_wb_valid;
  logic [DATA_W-1:0]     r_wb_data;

  logic                  w_ld;
  logic                  w_st;
  logic [MEM_AW-1:0]     w_addr;
  logic [DEPTH-1:0]      w_hit_vec;
  logic                  w_hit;
  logic [DATA_W-1:0]     w_hit_data;
  logic                  w_full;
  logic                  w_merge;
  logic                  w_enq;
  logic                  w_drain;
  logic                  w_head_bypass;
  logic [DATA_W-1:0]     w_drain_data;
  logic                  w_unused_addr_hi;

  assign w_ld             = sb.ex_valid & sb.ex_mem_read;
  assign w_st             = sb.ex_valid & sb.ex_mem_write & ~sb.ex_mem_read;
  assign w_addr           = sb.ex_addr[MEM_AW-1:0];
  assign w_unused_addr_hi = ^sb.ex_addr[ADDR_W-1:MEM_AW];

  sb_match u_match (
    .i_entries  (r_entries),
    .i_valid    (r_valid),
    .i_addr     (w_addr),
    .o_hit_vec  (w_hit_vec),
    .o_hit      (w_hit),
    .o_hit_data (w_hit_data)
  );

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_merge = w_st & w_hit;
  assign w_enq   = w_st & ~w_hit;

  // A load owns the port; otherwise drain when idle, flushing, near full, or a new store needs room.
  assign w_drain = ~w_ld && (r_count != '0) &&
                   (sb.sb_flush || ~sb.ex_valid || (r_count >= CNT_W'(DRAIN_THRESH)) ||
                    (w_st && w_full && ~w_hit));

  assign w_head_bypass = w_merge & w_hit_vec[r_head];
  assign w_drain_data  = w_head_bypass ? sb.ex_wdata : r_entries[r_head].data;

  assign sb.dm_read      = w_ld;
  assign sb.dm_write_en  = w_drain;
  assign sb.dm_addr      = w_ld    ? dm_addr_of(w_addr) :
                           w_drain ? dm_addr_of(r_entries[r_head].addr) : '0;
  assign sb.dm_wdata     = w_drain ? w_drain_data : '0;
  assign sb.sb_empty     = (r_count == '0);
  assign sb.wb_valid     = r_wb_valid;
  assign sb.wb_load_data = r_wb_data;

  // Enqueue is ordered after pop so a full buffer can retire the head and refill that slot together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entries <= '0;
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_merge && w_hit_vec[i]) r_entries[i].data <= sb.ex_wdata;
      end
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_enq) begin
        r_entries[r_tail] <= '{addr: w_addr, data: sb.ex_wdata};
        r_valid[r_tail]   <= 1'b1;
        r_tail            <= r_tail + PTR_W'(1);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
    end else if (w_ld) begin
      r_wb_valid <= 1'b1;
      r_wb_data  <= w_hit ? w_hit_data : sb.dm_rdata;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model, dataMemory model, directed + random stimulus.
module tb_store_buffer;
  import store_buffer_pkg::*;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic memInit;

  always #5 clk = ~clk;

  store_buffer_if sbIf();

  store_buffer dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbIf)
  );

  // dataMemory model: combinational read, write at the rising edge.
  logic [7:0] tbMem [16];

  function automatic logic [7:0] initVal(input int i);
    if (i == 5) return 8'h3C;
    return 8'(i * 37 + 17);
  endfunction

  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 16; i++) tbMem[i] <= initVal(i);
    end else if (sbIf.dm_write_en) begin
      tbMem[sbIf.dm_addr[3:0]] <= sbIf.dm_wdata;
    end
  end

  assign sbIf.dm_rdata = tbMem[sbIf.dm_addr[3:0]];

  // Reference model: ordered queue of pending stores plus the memory contents it implies.
  ent_t       q[$];
  logic [7:0] modelMem [16];
  logic       expWbValid;
  logic [7:0] expWbData;
  int         checks = 0;
  int         passes = 0;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int findIdx(input logic [3:0] a);
    for (int i = 0; i < q.size(); i++) if (q[i].addr == a) return i;
    return -1;
  endfunction

  task automatic checkOutput(input logic expEmpty, input logic expRead, input logic expWe,
                             input logic [7:0] expAddr, input logic [7:0] expWdata);
    checkEq("sb_empty",     32'(sbIf.sb_empty),     32'(expEmpty));
    checkEq("wb_valid",     32'(sbIf.wb_valid),     32'(expWbValid));
    checkEq("wb_load_data", 32'(sbIf.wb_load_data), 32'(expWbData));
    checkEq("dm_read",      32'(sbIf.dm_read),      32'(expRead));
    checkEq("dm_write_en",  32'(sbIf.dm_write_en),  32'(expWe));
    checkEq("dm_addr",      32'(sbIf.dm_addr),      32'(expAddr));
    if (!expRead) checkEq("dm_wdata", 32'(sbIf.dm_wdata), 32'(expWdata));
  endtask

  // One cycle: drive at the falling edge, check settled outputs, then advance the model past the rising edge.
  task automatic applyStimulus(input logic ev, input logic rd, input logic wr,
                               input logic [7:0] addr, input logic [7:0] wdata, input logic fl);
    logic       ld, st, drain;
    logic [3:0] a;
    logic [7:0] eAddr, eWdata;
    int         idx, cnt;
    @(negedge clk);
    sbIf.ex_valid     = ev;
    sbIf.ex_mem_read  = rd;
    sbIf.ex_mem_write = wr;
    sbIf.ex_addr      = addr;
    sbIf.ex_wdata     = wdata;
    sbIf.sb_flush     = fl;
    #2;
    ld    = ev && rd;
    st    = ev && wr && !rd;
    a     = addr[3:0];
    idx   = findIdx(a);
    cnt   = q.size();
    drain = !ld && cnt > 0 && (fl || !ev || cnt >= 3 || (st && cnt == 4 && idx < 0));
    eAddr  = 8'h00;
    eWdata = 8'h00;
    if (ld) eAddr = {4'h0, a};
    else if (drain) begin
      eAddr  = {4'h0, q[0].addr};
      eWdata = (st && idx == 0) ? wdata : q[0].data;
    end
    checkOutput(cnt == 0, ld, drain, eAddr, eWdata);
    if (ld) begin
      expWbValid = 1'b1;
      expWbData  = (idx >= 0) ? q[idx].data : modelMem[a];
    end else begin
      expWbValid = 1'b0;
    end
    if (st && idx >= 0) q[idx].data = wdata;
    if (drain) begin
      modelMem[q[0].addr] = eWdata;
      void'(q.pop_front());
    end
    if (st && idx < 0) q.push_back('{addr: a, data: wdata});
  endtask

  task automatic drainAll();
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    if (q.size() != 0) checkEq("drain bound", 32'(q.size()), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    sbIf.ex_valid = 1'b0; sbIf.ex_mem_read = 1'b0; sbIf.ex_mem_write = 1'b0;
    sbIf.sb_flush = 1'b0;
    #2;
    reset = 1'b1;
    q.delete();
    expWbValid = 1'b0;
    expWbData  = 8'h00;
    #1;
    checkEq("rst sb_empty", 32'(sbIf.sb_empty), 32'd1);
    checkEq("rst wb_valid", 32'(sbIf.wb_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    memInit = 1'b1;
    sbIf.ex_valid = 1'b0; sbIf.ex_mem_read = 1'b0; sbIf.ex_mem_write = 1'b0;
    sbIf.ex_addr = 8'h00; sbIf.ex_wdata = 8'h00; sbIf.sb_flush = 1'b0;
    for (int i = 0; i < 16; i++) modelMem[i] = initVal(i);
    expWbValid = 1'b0;
    expWbData  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    memInit = 1'b0;
    reset   = 1'b0;
    #2;
    checkEq("reset sb_empty",     32'(sbIf.sb_empty),     32'd1);
    checkEq("reset wb_valid",     32'(sbIf.wb_valid),     32'd0);
    checkEq("reset wb_load_data", 32'(sbIf.wb_load_data), 32'd0);
    checkEq("reset dm_read",      32'(sbIf.dm_read),      32'd0);
    checkEq("reset dm_write_en",  32'(sbIf.dm_write_en),  32'd0);
    checkEq("reset dm_addr",      32'(sbIf.dm_addr),      32'd0);

    // Load from memory with an empty buffer.
    applyStimulus(1, 1, 0, 8'h05, 8'h00, 0);
    checkEq("ld5 dm_read", 32'(sbIf.dm_read), 32'd1);
    checkEq("ld5 dm_addr", 32'(sbIf.dm_addr), 32'h05);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
    checkEq("ld5 wb_valid", 32'(sbIf.wb_valid),     32'd1);
    checkEq("ld5 wb_data",  32'(sbIf.wb_load_data), 32'h3C);

    // Three stores reach the threshold; the oldest drains first.
    applyStimulus(1, 0, 1, 8'h01, 8'hA1, 0);
    applyStimulus(1, 0, 1, 8'h02, 8'hA2, 0);
    applyStimulus(1, 0, 1, 8'h03, 8'hA3, 0);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
    checkEq("thresh dm_write_en", 32'(sbIf.dm_write_en), 32'd1);
    checkEq("thresh dm_addr",     32'(sbIf.dm_addr),     32'h01);
    checkEq("thresh dm_wdata",    32'(sbIf.dm_wdata),    32'hA1);
    drainAll();

    // Forward a buffered store to a load before memory is written.
    applyStimulus(1, 0, 1, 8'h07, 8'hAA, 0);
    applyStimulus(1, 1, 0, 8'h07, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
    checkEq("fwd wb_data",   32'(sbIf.wb_load_data), 32'hAA);
    checkEq("fwd mem7 old",  32'(tbMem[7]),          32'(initVal(7)));
    drainAll();
    checkEq("fwd mem7 new",  32'(tbMem[7]),          32'hAA);

    // Aliased addresses coalesce into one entry.
    applyStimulus(1, 0, 1, 8'h02, 8'h11, 0);
    applyStimulus(1, 0, 1, 8'h12, 8'h22, 0);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0);
    checkEq("alias dm_addr",  32'(sbIf.dm_addr),  32'h02);
    checkEq("alias dm_wdata", 32'(sbIf.dm_wdata), 32'h22);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
    checkEq("alias sb_empty", 32'(sbIf.sb_empty), 32'd1);
    checkEq("alias mem2",     32'(tbMem[2]),      32'h22);

    // Stream of stores to new addresses: nothing lost.
    for (int i = 8; i < 13; i++) applyStimulus(1, 0, 1, 8'(i), 8'(8'h80 + i), 0);
    drainAll();
    for (int i = 8; i < 13; i++) checkEq("stream mem", 32'(tbMem[i]), 32'(8'h80 + i));

    // Flush with interleaved loads: loads keep the port.
    applyStimulus(1, 0, 1, 8'h01, 8'h31, 0);
    applyStimulus(1, 0, 1, 8'h02, 8'h32, 0);
    applyStimulus(1, 0, 1, 8'h03, 8'h33, 0);
    applyStimulus(1, 1, 0, 8'h09, 8'h00, 1);
    checkEq("flush ld read", 32'(sbIf.dm_read),     32'd1);
    checkEq("flush ld we",   32'(sbIf.dm_write_en), 32'd0);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 1);
    checkEq("flush drain1",  32'(sbIf.dm_addr),     32'h01);
    applyStimulus(1, 1, 0, 8'h02, 8'h00, 1);
    checkEq("flush ld2 we",  32'(sbIf.dm_write_en), 32'd0);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 1);
    checkEq("flush fwd2",    32'(sbIf.wb_load_data), 32'h32);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 1);
    checkEq("flush not empty", 32'(sbIf.sb_empty),  32'd0);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0);
    checkEq("flush empty",   32'(sbIf.sb_empty),    32'd1);

    // Reset while a drain is pending.
    applyStimulus(1, 0, 1, 8'h04, 8'h44, 0);
    applyStimulus(1, 0, 1, 8'h05, 8'h55, 0);
    applyStimulus(1, 1, 0, 8'h04, 8'h00, 0);
    @(negedge clk);
    sbIf.ex_valid = 1'b0; sbIf.ex_mem_read = 1'b0; sbIf.sb_flush = 1'b1;
    #2;
    checkEq("pre-rst wb_valid",    32'(sbIf.wb_valid),    32'd1);
    checkEq("pre-rst dm_write_en", 32'(sbIf.dm_write_en), 32'd1);
    reset = 1'b1;
    q.delete();
    expWbValid = 1'b0;
    expWbData  = 8'h00;
    #1;
    checkEq("mid rst sb_empty",     32'(sbIf.sb_empty),     32'd1);
    checkEq("mid rst wb_valid",     32'(sbIf.wb_valid),     32'd0);
    checkEq("mid rst wb_load_data", 32'(sbIf.wb_load_data), 32'd0);
    checkEq("mid rst dm_write_en",  32'(sbIf.dm_write_en),  32'd0);
    @(negedge clk);
    sbIf.sb_flush = 1'b0;
    reset = 1'b0;

    // Randomized traffic over a small address window so merges and forwards are frequent.
    for (int c = 0; c < 400; c++) begin
      logic [7:0] ra;
      ra = {4'($urandom), 1'b0, 3'($urandom_range(0, 7))};
      if (c == 200) applyReset();
      applyStimulus(($urandom % 8) != 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
                    ra, 8'($urandom), ($urandom % 10) == 0);
    end
    drainAll();
    for (int i = 0; i < 16; i++) checkEq("final mem", 32'(tbMem[i]), 32'(modelMem[i]));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
